// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, fetch state encoding and widths for the 8-bit four-opcode core
package cpu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW = 2'b01;
  localparam logic [1:0] OP_SW = 2'b10;
  localparam logic [1:0] OP_J = 2'b11;
  localparam int INSTR_W = 8;
  localparam int JOFF_W = 6;
  typedef enum logic [1:0] {RESET_S, REQ, HOLD} fetch_state_e;
endpackage

// File: rtl/instr_fetch_pc_next.sv
// instr_fetch_pc_next: combinational next PC, increment plus optional sign-extended jump offset
module instr_fetch_pc_next
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0]   pc,
  input  logic [JOFF_W-1:0] off,
  input  logic              jump,
  output logic [PC_W-1:0]   pc_next
);
  assign pc_next = pc + PC_W'(1) + (jump ? PC_W'($signed(off)) : '0);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, single-outstanding imem req/ack fetch, valid/ready hand-off and jump redirect.
// Optional memory-wait counter enabled by INSTR_FETCH_STALL_CNT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               jump,
  output logic [15:0]        stall_cnt
);
  fetch_state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, instr_pc_q, instr_pc_d, pc_nxt;
  logic [INSTR_W-1:0] instr_q, instr_d;
  instr_fetch_pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc(instr_pc_q),
    .off(instr_q[JOFF_W-1:0]),
    .jump(jump),
    .pc_next(pc_nxt)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_pc_d = instr_pc_q;
    instr_d = instr_q;
    case (state_q)
      RESET_S: state_d = REQ;
      REQ: if (imem_ack) begin
        state_d = HOLD;
        instr_d = imem_rdata;
        instr_pc_d = pc_q;
      end
      HOLD: if (instr_ready) begin
        state_d = REQ;
        pc_d = pc_nxt;
      end
      default: state_d = RESET_S;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_S;
      pc_q <= RESET_PC;
      instr_pc_q <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_pc_q <= instr_pc_d;
      instr_q <= instr_d;
    end
  end
  assign imem_req = state_q == REQ;
  assign imem_addr = pc_q;
  assign instr_valid = state_q == HOLD;
  assign instr = instr_q;
  assign instr_pc = instr_pc_q;
`ifdef INSTR_FETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = (state_q == REQ && !imem_ack && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 8-bit four-opcode core (add/lw/sw/j). It holds the program counter and fetches one 8-bit instruction at a time from instruction memory over a req/ack handshake. It presents the instruction to decode/control with a valid/ready handshake and applies the jump redirect (PC-relative, 6-bit offset) when a `j` instruction is consumed. Its `instr[7:6]` output directly drives the control unit's opcode input.

## Interface
- `PC_W`, 8, program counter / instruction address width (must be ≥ 6)
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  core clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  PC_W  fetch address; equals current PC
- `imem_ack`  in  1  single-cycle pulse: `imem_rdata` valid this cycle
- `imem_rdata`  in  8  instruction word from memory
- `instr_valid`  out  1  `instr`/`instr_pc` hold a fetched instruction
- `instr`  out  8  instruction register (`[7:6]` = opcode)
- `instr_pc`  out  PC_W  address the instruction was fetched from
- `instr_ready`  in  1  decode consumes the instruction this cycle
- `jump`  in  1  control-unit Branch for `instr`; sampled only on accept
- `stall_cnt`  out  16  memory-wait cycle count (see Configuration)

## Operation
- **States:**
  - RESET_S: entered asynchronously on `rst`. Leaves one cycle after `rst` deasserts → REQ.
  - REQ: `imem_req`=1, `imem_addr`=PC held stable. On `imem_ack`: capture `imem_rdata` into `instr` and PC into `instr_pc`, then → HOLD.
  - HOLD: `instr_valid`=1, `instr`/`instr_pc` stable. On `instr_valid && instr_ready` (accept), update PC and → REQ.
- **Next PC on accept:**
  - `jump`=0: `instr_pc + 1`.
  - `jump`=1: `instr_pc + 1 + sext(instr[5:0])`.
  - All arithmetic is modulo 2^PC_W; wrap-around is silent.
- `imem_ack` outside REQ is ignored; `instr` is not modified.
- `instr_ready` outside HOLD is ignored.
- Only one memory request is ever outstanding. No prefetch and no speculative fetch past a jump.
- **Reset values:**
  - `imem_req`=0, `imem_addr`=RESET_PC
  - `instr_valid`=0, `instr`=8'h00, `instr_pc`=RESET_PC
  - `stall_cnt`=0
- **Reset mid-operation:** state, PC and counter clear immediately. `imem_req` drops asynchronously; memory must abandon the request. A late ack arriving in RESET_S is ignored.

## Timing
- Ack at edge N → `instr_valid`=1 from cycle N+1.
- Accept at edge M → `imem_req`=1 with the new PC from cycle M+1.
- Best-case throughput (zero-wait memory, ready held high): one instruction per 2 cycles.
- `imem_addr` changes only on the REQ entry edge.
- `instr_valid` deasserts the cycle after accept.
- `jump` and `instr_ready` must be stable before the accept edge. `jump` is combinational from `instr[7:6]` through the control unit.

## Configuration
- `INSTR_FETCH_STALL_CNT_EN` defined:
  - `stall_cnt` increments each cycle in REQ with `imem_ack`=0.
  - Saturates at 16'hFFFF and clears only on `rst`.
- Undefined: `stall_cnt` is tied to 16'h0000 and no counter flops exist. The port is always present.

## Structure
- **Shared package `cpu_pkg`:**
  - Opcode constants OP_ADD=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_J=2'b11.
  - Fetch state enum (RESET_S, REQ, HOLD).
  - `INSTR_W`=8 and `JOFF_W`=6.
- **One sub-module, `instr_fetch_pc_next`:** purely combinational next-PC (increment plus sign-extended offset), reusable by a future branch unit.

## Test plan
- Reset release, memory acks after 0 wait cycles:
  - First `imem_req` with `imem_addr`=0x00 two cycles after release.
  - rdata 0x12 → `instr`=0x12, `instr_pc`=0x00, `instr_valid`=1.
- Sequential run, `instr_ready` held 1, memory returns 0x00/0x41/0x82 → addresses 0x00, 0x01, 0x02 fetched at a one-instruction-per-2-cycles cadence.
- Forward jump: `instr`=0xC5 at `instr_pc`=0x10, `jump`=1 accepted → next `imem_addr`=0x16.
- Backward jump and wrap:
  - `instr`=0xFE at 0x01 → next `imem_addr`=0x00.
  - `instr`=0xC0 at 0xFF → next `imem_addr`=0x00.
- Backpressure and stalls:
  - `instr_ready`=0 for 5 cycles → `instr` stable, no `imem_req`.
  - Memory waits 3 cycles → `stall_cnt`=3 with the macro, 0 without.
- Async `rst` pulse while in REQ awaiting ack:
  - `imem_req` drops immediately and a later ack is ignored.
  - Refetch starts at RESET_PC and `stall_cnt` returns to 0.
